// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response signal bundle between a load/store requester
// (master) and a memory responder (slave).
interface dbus_sram_responder_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data, resp_err
  );
endinterface

// File: rtl/dbus_sram_responder.sv
// Single-outstanding data-bus responder backed by a byte-strobed word RAM;
// writes commit on the accept edge, responses arrive a fixed LATENCY later.
module dbus_sram_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  dbus_sram_responder_if.slave    bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          accept;
  logic          misaligned;
  logic          is_write;
  logic          unused_addr_bits;

  assign idx              = bus.req_addr[AW+1:2];
  assign is_write         = |bus.req_strobe;
  assign unused_addr_bits = ^bus.req_addr[31:AW+2];

  // Unknown size codes are treated as word accesses.
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = bus.req_addr[0];
      default: misaligned = |bus.req_addr[1:0];
    endcase
  end

  assign bus.resp_addr_ok = resetn & bus.req_valid &
                            ((state_q == IDLE) | (state_q == RESP));
  assign accept           = bus.resp_addr_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: state_d = IDLE;
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The RAM word is captured here so later writes cannot disturb an in-flight read.
    if (accept) begin
      state_d = (LATENCY == 1) ? RESP : WAIT;
      cnt_d   = CNT_LOAD;
      rdata_d = (misaligned || is_write) ? 32'h0 : mem[idx];
      err_d   = misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_strobe[i]) mem[idx][8*i +: 8] <= bus.req_data[8*i +: 8];
      end
    end
  end

  assign bus.resp_data_ok = (state_q == RESP);
  assign bus.resp_data    = bus.resp_data_ok ? rdata_q : 32'h0;
  assign bus.resp_err     = bus.resp_data_ok & err_q;

endmodule
